// File: rtl/cmp_stage_pkg.sv
// Shared types and defaults for the compare-stage operand stager.
// Optional statistics are enabled by defining STAGER_STATS_EN.
package cmp_stage_pkg;

   localparam int CMP_DEPTH_DEFAULT = 4;
   localparam int CMP_W_DEFAULT     = 8;

   typedef struct packed {
      logic [CMP_W_DEFAULT-1:0] a;
      logic [CMP_W_DEFAULT-1:0] b;
   } cmp_pair_t;

   typedef enum logic {
      RES_EMPTY = 1'b0,
      RES_FULL  = 1'b1
   } res_state_e;

endpackage

// File: rtl/cmp_pair_fifo.sv
// Operand-pair FIFO: register storage, wrapping pointers and occupancy count.
// The head entry is presented combinationally; no write-to-read bypass.
module cmp_pair_fifo
   import cmp_stage_pkg::*;
#(
   parameter int W     = CMP_W_DEFAULT,
   parameter int DEPTH = CMP_DEPTH_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  logic [2*W-1:0] wr_data,
   output logic [2*W-1:0] head,
   output logic           full,
   output logic           empty
);

   localparam int AW = $clog2(DEPTH);

   logic [2*W-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
      end
   end

   // NOTE: the array is small and is reset so the head (and cmp_a/cmp_b) leave reset at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/cmp_operand_stager.sv
// Operand stager around a combinational a>=b comparator: input FIFO plus a registered result slot.
// Define STAGER_STATS_EN to add the saturating lt_count statistics port.
module cmp_operand_stager
   import cmp_stage_pkg::*;
#(
   parameter int W     = CMP_W_DEFAULT,
   parameter int DEPTH = CMP_DEPTH_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic [W-1:0]     cmp_a,
   output logic [W-1:0]     cmp_b,
   input  logic             cmp_y,
   input  logic             cmp_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_ge,
   output logic [W-1:0]     out_a,
   output logic [W-1:0]     out_b,
`ifdef STAGER_STATS_EN
   output logic [CNT_W-1:0] lt_count,
`endif
   output logic             err
);

   localparam logic [0:0] ST_EMPTY = RES_EMPTY;
   localparam logic [0:0] ST_FULL  = RES_FULL;

   logic [0:0]     state;
   logic [0:0]     state_nxt;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [2*W-1:0] head;

   cmp_pair_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data ({in_a, in_b}),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_ready     = !fifo_full;
   assign push         = in_valid && in_ready;
   // The head is consumed whenever the result slot is free or is being drained this cycle.
   assign pop          = !fifo_empty && ((state == ST_EMPTY) || out_ready);
   assign {cmp_a, cmp_b} = head;
   assign out_valid    = (state == ST_FULL);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (pop)
         state_nxt = ST_FULL;
      else if (out_ready)
         state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         out_ge <= 1'b0;
         out_a  <= '0;
         out_b  <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            out_ge <= cmp_y;
            out_a  <= cmp_a;
            out_b  <= cmp_b;
            if (!cmp_z) err <= 1'b1;
         end
      end
   end

`ifdef STAGER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lt_count <= '0;
      else if (pop && !cmp_y && (lt_count != '1))
         lt_count <= lt_count + CNT_W'(1);
   end
`endif

endmodule
